// File: rtl/uart_frame_tx_arbiter_pkg.sv
// Shared definitions for the UART frame transmit arbiter and the receive-side
// frame assembler: frame length, grant encoding, FSM state encoding and a
// small byte helper.
package uart_frame_tx_arbiter_pkg;

  // Bytes per frame; the receive side concatenates byte 1, 2, 3 MSB first.
  localparam int FRAME_BYTES = 3;

  // Grant encoding: which requester owns the current or last frame.
  localparam logic GRANT_P1 = 1'b0;
  localparam logic GRANT_P2 = 1'b1;

  // Transmit FSM state encoding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  // A 0x00 byte marks an empty slot on the receive side, so it can never
  // appear inside a transmitted frame.
  function automatic logic byte_is_empty(input logic [7:0] b);
    return (b == 8'h00);
  endfunction

endpackage

// File: rtl/uart_frame_tx_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter, purely combinational.
// Ports:
//   req_1, req_2 : pending requests
//   last_grant   : requester served most recently (GRANT_P1 / GRANT_P2)
//   sel          : selected requester (GRANT_P1 / GRANT_P2), valid only with valid
//   valid        : at least one request pending
module uart_frame_tx_arbiter_rr_arbiter2
  import uart_frame_tx_arbiter_pkg::*;
(
  input  logic req_1,
  input  logic req_2,
  input  logic last_grant,
  output logic sel,
  output logic valid
);

  // Pick the lone requester, or on contention the one not served last.
  always_comb begin
    valid = req_1 | req_2;
    sel   = GRANT_P1;
    if (req_1 && req_2) begin
      sel = (last_grant == GRANT_P1) ? GRANT_P2 : GRANT_P1;
    end else if (req_2) begin
      sel = GRANT_P2;
    end else begin
      sel = GRANT_P1;
    end
  end

endmodule

// File: rtl/uart_frame_tx_arbiter.sv
// Shares one UART transmitter between two requesters. Each captured word is
// sent as an N_BYTES frame, MSB byte first, paced by the transmitter's done
// tick. Words containing a 0x00 byte are acknowledged but discarded.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   req_x / data_x       : requester x pending flag (level) and word
//   ack_x                : one-cycle pulse, word x captured (sent or dropped)
//   tx_start / tx_data   : start strobe and byte towards uart_tx
//   tx_done_tick         : uart_tx finished the current byte
//   busy                 : high whenever the FSM is not idle
//   grant                : source of the current or last frame (0 = req_1)
//   drop_zero            : one-cycle pulse, captured word discarded (0x00 byte)
module uart_frame_tx_arbiter
  import uart_frame_tx_arbiter_pkg::*;
#(
  parameter int N_BYTES = FRAME_BYTES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_1,
  input  logic [8*N_BYTES-1:0] data_1,
  output logic                 ack_1,
  input  logic                 req_2,
  input  logic [8*N_BYTES-1:0] data_2,
  output logic                 ack_2,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_done_tick,
  output logic                 busy,
  output logic                 grant,
  output logic                 drop_zero
);

  localparam int W     = 8 * N_BYTES;
  localparam int CNT_W = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_BYTES - 1);

  state_e           state_r, state_nx_s;
  logic [W-1:0]     shift_r, shift_nx_s;
  logic [CNT_W-1:0] cnt_r, cnt_nx_s;
  logic             last_grant_r, last_grant_nx_s;
  logic             grant_r, grant_nx_s;
  logic             ack_1_r, ack_1_nx_s;
  logic             ack_2_r, ack_2_nx_s;
  logic             drop_zero_r, drop_zero_nx_s;
  logic             tx_start_r, tx_start_nx_s;
  logic [7:0]       tx_data_r, tx_data_nx_s;
  logic             busy_r, busy_nx_s;

  logic             req_1_eff_s, req_2_eff_s;
  logic             arb_sel_s, arb_valid_s;
  logic [W-1:0]     sel_word_s;
  logic             has_zero_s;

  // A requester still sees its own ack during the ack cycle and only drops
  // req afterwards; masking it here keeps a dropped word from being
  // captured a second time while the FSM is still idle.
  assign req_1_eff_s = req_1 & ~ack_1_r;
  assign req_2_eff_s = req_2 & ~ack_2_r;

  uart_frame_tx_arbiter_rr_arbiter2 u_rr (
    .req_1      (req_1_eff_s),
    .req_2      (req_2_eff_s),
    .last_grant (last_grant_r),
    .sel        (arb_sel_s),
    .valid      (arb_valid_s)
  );

  assign sel_word_s = (arb_sel_s == GRANT_P2) ? data_2 : data_1;

  // Flag a selected word that contains any empty (0x00) byte.
  always_comb begin
    has_zero_s = 1'b0;
    for (int i = 0; i < N_BYTES; i++) begin
      if (byte_is_empty(sel_word_s[8*i +: 8])) begin
        has_zero_s = 1'b1;
      end else begin
        has_zero_s = has_zero_s;
      end
    end
  end

  // Next-state and next-output logic of the transmit FSM.
  always_comb begin
    state_nx_s      = state_r;
    shift_nx_s      = shift_r;
    cnt_nx_s        = cnt_r;
    last_grant_nx_s = last_grant_r;
    grant_nx_s      = grant_r;
    ack_1_nx_s      = 1'b0;
    ack_2_nx_s      = 1'b0;
    drop_zero_nx_s  = 1'b0;
    tx_start_nx_s   = 1'b0;
    tx_data_nx_s    = tx_data_r;

    case (state_r)
      ST_IDLE: begin
        if (arb_valid_s) begin
          // Grant history advances even for dropped words so neither
          // requester can be starved by the other's empty slots.
          last_grant_nx_s = arb_sel_s;
          grant_nx_s      = arb_sel_s;
          ack_1_nx_s      = (arb_sel_s == GRANT_P1);
          ack_2_nx_s      = (arb_sel_s == GRANT_P2);
          if (has_zero_s) begin
            drop_zero_nx_s = 1'b1;
            state_nx_s     = ST_IDLE;
          end else begin
            shift_nx_s    = sel_word_s;
            cnt_nx_s      = {CNT_W{1'b0}};
            tx_start_nx_s = 1'b1;
            tx_data_nx_s  = sel_word_s[W-1 -: 8];
            state_nx_s    = ST_SEND;
          end
        end else begin
          state_nx_s = ST_IDLE;
        end
      end

      ST_SEND: begin
        state_nx_s = ST_WAIT;
      end

      ST_WAIT: begin
        if (tx_done_tick) begin
          if (cnt_r == LAST_CNT) begin
            state_nx_s = ST_IDLE;
          end else begin
            cnt_nx_s      = cnt_r + CNT_W'(1);
            shift_nx_s    = {shift_r[W-9:0], 8'h00};
            tx_start_nx_s = 1'b1;
            tx_data_nx_s  = shift_r[W-9 -: 8];
            state_nx_s    = ST_SEND;
          end
        end else begin
          state_nx_s = ST_WAIT;
        end
      end

      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase

    busy_nx_s = (state_nx_s != ST_IDLE);
  end

  // State, datapath and registered outputs; reset wins over all inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      shift_r      <= {W{1'b0}};
      cnt_r        <= {CNT_W{1'b0}};
      last_grant_r <= GRANT_P2;
      grant_r      <= 1'b0;
      ack_1_r      <= 1'b0;
      ack_2_r      <= 1'b0;
      drop_zero_r  <= 1'b0;
      tx_start_r   <= 1'b0;
      tx_data_r    <= 8'h00;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_nx_s;
      shift_r      <= shift_nx_s;
      cnt_r        <= cnt_nx_s;
      last_grant_r <= last_grant_nx_s;
      grant_r      <= grant_nx_s;
      ack_1_r      <= ack_1_nx_s;
      ack_2_r      <= ack_2_nx_s;
      drop_zero_r  <= drop_zero_nx_s;
      tx_start_r   <= tx_start_nx_s;
      tx_data_r    <= tx_data_nx_s;
      busy_r       <= busy_nx_s;
    end
  end

  assign ack_1     = ack_1_r;
  assign ack_2     = ack_2_r;
  assign drop_zero = drop_zero_r;
  assign tx_start  = tx_start_r;
  assign tx_data   = tx_data_r;
  assign busy      = busy_r;
  assign grant     = grant_r;

endmodule
